// File: rtl/mac_unit_pkg.sv
// Shared types for the execute-stage multiply-accumulate engine: control codes, FSM states, default widths.
package mac_unit_pkg;

  localparam int MAC_XLEN  = 32;
  localparam int MAC_ACC_W = 64;

  typedef logic [2:0] mac_control_t;

  // Code 0 and 5..7 are not issued by the decoder and behave as no-ops.
  localparam mac_control_t MAC_CONTROL_NONE  = 3'd0;
  localparam mac_control_t MAC_CONTROL_MADD  = 3'd1;
  localparam mac_control_t MAC_CONTROL_MSUB  = 3'd2;
  localparam mac_control_t MAC_CONTROL_MMUL  = 3'd3;
  localparam mac_control_t MAC_CONTROL_MLOAD = 3'd4;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_MUL  = 2'd1,
    MAC_ACC  = 2'd2
  } mac_state_t;

  function automatic logic mac_is_arith(input mac_control_t ctrl);
    return (ctrl == MAC_CONTROL_MADD) || (ctrl == MAC_CONTROL_MSUB) ||
           (ctrl == MAC_CONTROL_MMUL);
  endfunction

endpackage

// File: rtl/mac_unit_mul_seq.sv
// Unsigned radix-2 shift-add multiplier: one multiplier bit per cycle, XLEN cycles after i_start.
// o_done is high during the last iteration; o_prod is final on the following cycle.
module mac_mul_seq #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic              o_done,
  output logic [2*XLEN-1:0] o_prod
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [2*XLEN-1:0] r_prod;
  logic [CW-1:0]     r_cnt;
  logic              r_active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{XLEN{1'b0}}, i_a};
      r_mplier <= i_b;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (i_abort) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (r_active) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == CW'(XLEN - 1)) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_done = r_active && (r_cnt == CW'(XLEN - 1));
  assign o_prod = r_prod;

endmodule

// File: rtl/mac_unit.sv
// Multiply-accumulate engine with private accumulator; MADD/MSUB/MMUL take XLEN+2 cycles start-to-done, MLOAD one.
// Optional MAC_SAT_EN: saturate MADD/MSUB on signed overflow and raise a sticky sat_flag.
module mac_unit
  import mac_unit_pkg::*;
#(
  parameter int XLEN  = MAC_XLEN,
  parameter int ACC_W = MAC_ACC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mac_write,
  input  mac_control_t     mac_control,
  input  logic [XLEN-1:0]  src_a,
  input  logic [XLEN-1:0]  src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat_flag
);

  mac_state_t        r_state;
  mac_control_t      r_op;
  logic              r_sign;
  logic [ACC_W-1:0]  r_acc;
  logic              r_busy;
  logic              r_done;

  logic              w_start;
  logic              w_load;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_mul_done;
  logic [2*XLEN-1:0] w_prod;
  logic [ACC_W-1:0]  w_p_mag;
  logic [ACC_W-1:0]  w_p;
  logic [ACC_W-1:0]  w_sum;
  logic [ACC_W-1:0]  w_diff;
  logic [ACC_W-1:0]  w_acc_nxt;

  // Flush in IDLE swallows a coincident start.
  assign w_start = (r_state == MAC_IDLE) && mac_write && !flush && mac_is_arith(mac_control);
  assign w_load  = (r_state == MAC_IDLE) && mac_write && !flush && (mac_control == MAC_CONTROL_MLOAD);

  assign w_abs_a = src_a[XLEN-1] ? -src_a : src_a;
  assign w_abs_b = src_b[XLEN-1] ? -src_b : src_b;

  mac_mul_seq #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_abort (flush && (r_state == MAC_MUL)),
    .i_a     (w_abs_a),
    .i_b     (w_abs_b),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  assign w_p_mag = ACC_W'(w_prod);
  assign w_p     = r_sign ? -w_p_mag : w_p_mag;
  assign w_sum   = r_acc + w_p;
  assign w_diff  = r_acc - w_p;

`ifdef MAC_SAT_EN
  logic             r_sat;
  logic             w_ovf;
  logic [ACC_W-1:0] w_sat_val;

  // Overflow: operands agree in sign (after negation for MSUB) but the result does not.
  assign w_ovf = ((r_op == MAC_CONTROL_MADD) && (r_acc[ACC_W-1] == w_p[ACC_W-1]) &&
                  (w_sum[ACC_W-1] != r_acc[ACC_W-1])) ||
                 ((r_op == MAC_CONTROL_MSUB) && (r_acc[ACC_W-1] != w_p[ACC_W-1]) &&
                  (w_diff[ACC_W-1] != r_acc[ACC_W-1]));
  assign w_sat_val = r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sat <= 1'b0;
    else if ((r_state == MAC_ACC) && !flush && w_ovf) r_sat <= 1'b1;
  end

  assign sat_flag = r_sat;
`else
  assign sat_flag = 1'b0;
`endif

  always_comb begin
    w_acc_nxt = r_acc;
    case (r_op)
      MAC_CONTROL_MADD: w_acc_nxt = w_sum;
      MAC_CONTROL_MSUB: w_acc_nxt = w_diff;
      MAC_CONTROL_MMUL: w_acc_nxt = w_p;
      default:          w_acc_nxt = r_acc;
    endcase
`ifdef MAC_SAT_EN
    if (w_ovf) w_acc_nxt = w_sat_val;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MAC_IDLE;
      r_op    <= MAC_CONTROL_MADD;
      r_sign  <= 1'b0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MAC_IDLE: begin
          if (w_start) begin
            r_state <= MAC_MUL;
            r_op    <= mac_control;
            r_sign  <= src_a[XLEN-1] ^ src_b[XLEN-1];
            r_busy  <= 1'b1;
          end else if (w_load) begin
            r_acc  <= {{(ACC_W-XLEN){src_a[XLEN-1]}}, src_a};
            r_done <= 1'b1;
          end
        end
        MAC_MUL: begin
          if (flush) begin
            r_state <= MAC_IDLE;
            r_busy  <= 1'b0;
          end else if (w_mul_done) begin
            r_state <= MAC_ACC;
          end
        end
        MAC_ACC: begin
          r_state <= MAC_IDLE;
          r_busy  <= 1'b0;
          if (!flush) begin
            r_acc  <= w_acc_nxt;
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= MAC_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign acc_out = r_acc;

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: directed scenarios with literal results, then randomized ops against a timeline model.
module tb_mac_unit;
  import mac_unit_pkg::*;

  localparam int XLEN = 32;
`ifdef MAC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         mac_write;
  mac_control_t mac_control;
  logic [31:0]  src_a, src_b;
  logic         flush;
  logic         busy, done, sat_flag;
  logic [63:0]  acc_out;

  logic         exp_busy, exp_done, exp_sat;
  logic [63:0]  exp_acc;
  bit           chk_en;
  int           n_chk, n_err;

  always #5 clk = ~clk;

  mac_unit dut (
    .clk         (clk),
    .reset       (reset),
    .mac_write   (mac_write),
    .mac_control (mac_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .acc_out     (acc_out),
    .sat_flag    (sat_flag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact signed arithmetic in 66 bits, then wrap or clamp to the 64-bit range.
  function automatic logic [63:0] model_res(input mac_control_t op, input logic [63:0] acc,
                                            input logic [31:0] a, input logic [31:0] b,
                                            output bit ovf);
    longint pa, pb, p;
    logic signed [65:0] wa, wp, wr;
    logic signed [65:0] maxv, minv;
    maxv = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    minv = -maxv - 66'sd1;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = pa * pb;
    wa = {{2{acc[63]}}, acc};
    wp = {{2{p[63]}}, p};
    case (op)
      MAC_CONTROL_MADD: wr = wa + wp;
      MAC_CONTROL_MSUB: wr = wa - wp;
      default:          wr = wp;
    endcase
    ovf = (op != MAC_CONTROL_MMUL) && ((wr > maxv) || (wr < minv));
    if (SAT_EN && ovf) return (wr > 0) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
    return wr[63:0];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {63'd0, busy}, {63'd0, exp_busy});
      chk("done", {63'd0, done}, {63'd0, exp_done});
      chk("acc_out", acc_out, exp_acc);
      chk("sat_flag", {63'd0, sat_flag}, {63'd0, exp_sat});
    end
  end

  // flush_at / wr_at: busy-cycle index (1..XLEN+1) at which to flush or pulse a stray write; 0 = never.
  task automatic do_op(input mac_control_t ctrl, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at, input int wr_at);
    bit ovf;
    logic [63:0] res;
    mac_write = 1'b1; mac_control = ctrl; src_a = a; src_b = b;
    tick();
    mac_write = 1'b0; src_a = $urandom; src_b = $urandom; mac_control = 3'($urandom);
    if (ctrl == MAC_CONTROL_MLOAD) begin
      exp_acc = {{32{a[31]}}, a};
      exp_done = 1'b1;
      tick();
      exp_done = 1'b0;
    end else if (mac_is_arith(ctrl)) begin
      res = model_res(ctrl, exp_acc, a, b, ovf);
      exp_busy = 1'b1;
      for (int i = 1; i <= XLEN + 1; i++) begin
        if (i == flush_at) flush = 1'b1;
        if (i == wr_at) begin
          mac_write = 1'b1; mac_control = MAC_CONTROL_MLOAD;
        end
        tick();
        flush = 1'b0; mac_write = 1'b0; src_a = $urandom; src_b = $urandom;
        if (i == flush_at) begin
          exp_busy = 1'b0;
          return;
        end
      end
      exp_busy = 1'b0; exp_done = 1'b1; exp_acc = res;
      exp_sat = exp_sat | (SAT_EN & ovf);
      tick();
      exp_done = 1'b0;
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] lit;
    mac_control_t bad_ops [4];
    bad_ops = '{3'd0, 3'd5, 3'd6, 3'd7};
    n_chk = 0; n_err = 0;
    reset = 1'b1; mac_write = 1'b0; mac_control = MAC_CONTROL_NONE;
    src_a = '0; src_b = '0; flush = 1'b0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_sat = 1'b0; exp_acc = '0;
    chk_en = 1'b1;
    tick(); tick();
    chk("reset_acc", acc_out, 64'h0);
    chk("reset_busy", {63'd0, busy}, 64'h0);
    reset = 1'b0;
    tick();

    do_op(MAC_CONTROL_MLOAD, 32'h0000_0005, 32'h0, 0, 0);
    chk("mload_5", acc_out, 64'h0000_0000_0000_0005);
    do_op(MAC_CONTROL_MADD, 32'd3, 32'hFFFF_FFFC, 0, 0);
    chk("madd_3x-4", acc_out, 64'hFFFF_FFFF_FFFF_FFF9);
    do_op(MAC_CONTROL_MSUB, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 0);
    chk("msub_-2x-3", acc_out, 64'hFFFF_FFFF_FFFF_FFF3);
    do_op(MAC_CONTROL_MMUL, 32'h8000_0000, 32'h8000_0000, 0, 0);
    chk("mmul_min_sq", acc_out, 64'h4000_0000_0000_0000);
    do_op(MAC_CONTROL_MADD, 32'd9, 32'd9, 10, 0);
    chk("flush_mul10", acc_out, 64'h4000_0000_0000_0000);
    do_op(MAC_CONTROL_MADD, 32'd2, 32'd3, 0, 5);
    chk("write_in_busy", acc_out, 64'h4000_0000_0000_0006);
    do_op(MAC_CONTROL_MMUL, 32'd7, 32'd7, XLEN + 1, 0);
    chk("flush_acc", acc_out, 64'h4000_0000_0000_0006);

    // Flush beats a coincident MLOAD in IDLE.
    mac_write = 1'b1; flush = 1'b1; mac_control = MAC_CONTROL_MLOAD; src_a = 32'h1234;
    tick();
    mac_write = 1'b0; flush = 1'b0;
    tick();
    chk("idle_flush_drop", acc_out, 64'h4000_0000_0000_0006);

    do_op(MAC_CONTROL_MLOAD, 32'h7FFF_FFFF, 32'h0, 0, 0);
    repeat (3) do_op(MAC_CONTROL_MADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0);
    lit = SAT_EN ? 64'h7FFF_FFFF_FFFF_FFFF : 64'hBFFF_FFFD_8000_0002;
    chk("sat_seq_acc", acc_out, lit);
    chk("sat_seq_flag", {63'd0, sat_flag}, {63'd0, SAT_EN});
    do_op(MAC_CONTROL_MADD, 32'd1, 32'd1, 0, 0);
    chk("sat_sticky", {63'd0, sat_flag}, {63'd0, SAT_EN});

    // Asynchronous reset in the middle of MUL cycle 5.
    mac_write = 1'b1; mac_control = MAC_CONTROL_MADD; src_a = 32'd11; src_b = 32'd13;
    tick();
    mac_write = 1'b0; exp_busy = 1'b1;
    repeat (4) tick();
    #1;
    reset = 1'b1;
    exp_busy = 1'b0; exp_done = 1'b0; exp_acc = '0; exp_sat = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, busy}, 64'h0);
    chk("rst_mid_acc", acc_out, 64'h0);
    chk("rst_mid_sat", {63'd0, sat_flag}, 64'h0);
    tick();
    reset = 1'b0;
    tick();

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1: do_op(MAC_CONTROL_MLOAD, rnd_val(), 32'h0, 0, 0);
        2: begin
          mac_write = 1'b1; mac_control = bad_ops[$urandom_range(0, 3)]; src_a = $urandom;
          tick();
          mac_write = 1'b0;
        end
        3: begin
          mac_write = 1'b1; flush = 1'b1; src_a = $urandom; src_b = $urandom;
          mac_control = mac_control_t'($urandom_range(1, 4));
          tick();
          mac_write = 1'b0; flush = 1'b0;
        end
        default: begin
          int fa, wa;
          fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, XLEN + 1) : 0;
          wa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, XLEN + 1) : 0;
          do_op(mac_control_t'($urandom_range(1, 3)), rnd_val(), rnd_val(), fa, wa);
        end
      endcase
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
    end

    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mac_unit.md
Name: mac_unit

Overview:
- Execute-stage multiply-accumulate engine.
- Consumes the mac_write / mac_control pair produced by the main decoder (opcodes 1111000–1111011) after it is carried down the ID/EX pipeline register, together with the two register operands.
- Holds a private accumulator and computes signed XLEN×XLEN products iteratively.
- Raises busy to stall the pipeline until the result is committed.

Parameters:
- XLEN, 32, operand width.
- ACC_W, 64, accumulator width; must satisfy ACC_W >= 2*XLEN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mac_write  input  1  start request; sampled only in IDLE.
- mac_control  input  mac_control_t  operation: MAC_CONTROL_MADD / MSUB / MMUL / MLOAD.
- src_a  input  XLEN  signed multiplicand (rs1); also the MLOAD value.
- src_b  input  XLEN  signed multiplier (rs2).
- flush  input  1  abort the in-flight operation (branch/jump flush).
- busy  output  1  high while an operation is in progress; drives the pipeline stall.
- done  output  1  one-cycle pulse when the accumulator has just been updated.
- acc_out  output  ACC_W  current accumulator contents.
- sat_flag  output  1  sticky saturation indicator (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state): state=IDLE, acc_out=0, busy=0, done=0, sat_flag=0, multiplier registers cleared. Reset during MUL discards the operation.
- States: IDLE, MUL, ACC.
- IDLE:
  - mac_write=1 with MADD/MSUB/MMUL: latch |src_a|, |src_b|, product sign and op; clear partial product and bit counter; go to MUL.
  - mac_write=1 with MLOAD: acc <= sign-extended src_a; done=1 on the next cycle; state stays IDLE; busy stays 0.
- MUL: radix-2 shift-add, one multiplier bit per cycle; exactly XLEN cycles; counter wraps at XLEN-1 → ACC.
- ACC (1 cycle): apply sign to the 2*XLEN magnitude product, sign-extend to ACC_W, then:
  - MADD: acc <= acc + p
  - MSUB: acc <= acc − p
  - MMUL: acc <= p
  - next state IDLE; done=1 in the following cycle.
- Latency, start edge t0 to done: XLEN+2 cycles (34 at default). busy high from t0+1 through the ACC cycle (XLEN+1 cycles); busy low in the done cycle.
- busy and done are registered outputs.
- Arithmetic is two's complement, modulo 2^ACC_W (wraps) unless MAC_SAT_EN is defined.
- mac_write while busy: ignored, no queuing; the pipeline is stalled in that case anyway.
- flush in MUL or ACC: next state IDLE, acc unchanged, no done pulse. flush in IDLE: no effect; a simultaneous mac_write is dropped.
- mac_write with flush in the same IDLE cycle: flush wins.
- Invalid mac_control value: treated as no-op; stay in IDLE.
- src_a / src_b need only be valid in the start cycle.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: the ACC result saturates to the signed ACC_W maximum/minimum on overflow of MADD/MSUB; sat_flag is set and stays sticky until reset.
- Undefined: results wrap; sat_flag is tied to 0.

Decomposition:
- mac_control_t and its MAC_CONTROL_* values remain in the shared package types.
- Add to types: mac_state_t enum (MAC_IDLE, MAC_MUL, MAC_ACC), and constants MAC_XLEN=32 and MAC_ACC_W=64.
- One sub-module: mac_mul_seq.
  - Contains the iterative unsigned shift-add multiplier.
  - Interface: start, the two operands, done strobe and the 2*XLEN product.
  - mac_unit keeps the FSM, sign fix-up, accumulate and saturation logic.

Test Plan:
- Assert reset → acc_out=0, busy=0, done=0, sat_flag=0. Reassert reset at MUL cycle 5 → all outputs 0 immediately, state IDLE.
- MLOAD src_a=0x0000_0005 → next cycle acc_out=0x0000_0000_0000_0005, done=1 for one cycle, busy never high.
- From acc=5, MADD src_a=3, src_b=0xFFFF_FFFC (−4) → busy high 33 cycles; done at t0+34; acc_out=0xFFFF_FFFF_FFFF_FFF9 (−7).
- From acc=−7, MSUB src_a=−2, src_b=−3 → acc=−13 (0xFFFF_FFFF_FFFF_FFF3). Then MMUL 0x8000_0000 × 0x8000_0000 → acc=0x4000_0000_0000_0000.
- MADD started, flush at MUL cycle 10 → busy=0 next cycle, acc unchanged, no done. A mac_write pulsed during busy → ignored, result unaffected.
- MAC_SAT_EN defined: MLOAD 0x7FFF_FFFF, then repeated MADD 0x7FFF_FFFF × 0x7FFF_FFFF until overflow → acc=0x7FFF_FFFF_FFFF_FFFF, sat_flag=1 and held. Without the macro, the same sequence wraps negative and sat_flag=0.
